// File: rtl/ik_jacobian_transpose_step.sv
// rtl/ik_jacobian_transpose_step.sv - one Jacobian-transpose IK update, delta_theta = alpha * J^T * e
module ik_jacobian_transpose_step #(
    parameter int W    = 27,
    parameter int FRAC = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [5:0][5:0][W-1:0]    jacobian_matrix,
    input  logic [5:0][W-1:0]         pose_error,
    input  logic [W-1:0]              alpha,
    input  logic [5:0]                joint_enable,
    output logic                      busy,
    output logic                      done,
    output logic [5:0][W-1:0]         delta_theta,
    output logic [5:0]                sat
);

    localparam int ACC_W = 2 * W - FRAC + 3;
    localparam int PW    = 2 * W;
    localparam int SW    = ACC_W + W;
    localparam logic signed [SW-1:0] SMAX = {{(SW - W + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MAC, SCALE, FIN} state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 k_q;
    logic [5:0][5:0][W-1:0]     j_q;
    logic [5:0][W-1:0]          e_q;
    logic [W-1:0]               a_q;
    logic [5:0]                 en_q;
    logic signed [ACC_W-1:0]    acc_q [6];
    logic signed [ACC_W-1:0]    acc_d [6];
    logic signed [PW-1:0]       prod  [6];
    logic signed [SW-1:0]       scaled [6];
    logic signed [SW-1:0]       shifted [6];
    logic [5:0][W-1:0]          dt_d;
    logic [5:0]                 sat_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MAC;
            MAC:     if (k_q == 3'd5) state_d = SCALE;
            SCALE:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);

    // Row k of the snapshot feeds all six column multipliers this cycle.
    always_comb begin
        dt_d  = '0;
        sat_d = '0;
        for (int c = 0; c < 6; c++) begin
            prod[c]    = $signed(j_q[k_q][c]) * $signed(e_q[k_q]);
            acc_d[c]   = acc_q[c] + ACC_W'(prod[c] >>> FRAC);
            scaled[c]  = acc_q[c] * $signed(a_q);
            shifted[c] = scaled[c] >>> FRAC;
            if (!en_q[c]) begin
                dt_d[c]  = '0;
                sat_d[c] = 1'b0;
            end else if (shifted[c] > SMAX) begin
                dt_d[c]  = W'(SMAX);
                sat_d[c] = 1'b1;
            end else if (shifted[c] < SMIN) begin
                dt_d[c]  = W'(SMIN);
                sat_d[c] = 1'b1;
            end else begin
                dt_d[c]  = W'(shifted[c]);
                sat_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            j_q         <= '0;
            e_q         <= '0;
            a_q         <= '0;
            en_q        <= '0;
            delta_theta <= '0;
            sat         <= '0;
            for (int c = 0; c < 6; c++) acc_q[c] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        j_q  <= jacobian_matrix;
                        e_q  <= pose_error;
                        a_q  <= alpha;
                        en_q <= joint_enable;
                        k_q  <= '0;
                        for (int c = 0; c < 6; c++) acc_q[c] <= '0;
                    end
                end
                MAC: begin
                    k_q <= k_q + 3'd1;
                    for (int c = 0; c < 6; c++) acc_q[c] <= acc_d[c];
                end
                SCALE: begin
                    delta_theta <= dt_d;
                    sat         <= sat_d;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ik_jacobian_transpose_step.sv
// tb/tb_ik_jacobian_transpose_step.sv - randomized self-checking bench for ik_jacobian_transpose_step
module tb_ik_jacobian_transpose_step;

    localparam int W = 27;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [5:0][5:0][W-1:0] jm;
    logic [5:0][W-1:0]      pe;
    logic [W-1:0]           alpha;
    logic [5:0]             en;
    logic                   busy, done;
    logic [5:0][W-1:0]      delta_theta;
    logic [5:0]             sat;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int phase = -1;
    bit chk_en = 1'b0;
    logic [5:0][W-1:0] exp_d, pend_d;
    logic [5:0]        exp_s, pend_s;

    ik_jacobian_transpose_step #(.W(W), .FRAC(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .jacobian_matrix(jm), .pose_error(pe), .alpha(alpha), .joint_enable(en),
        .busy(busy), .done(done), .delta_theta(delta_theta), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: delta = alpha * J^T * e with floor shifts, then clip to W bits.
    function automatic void model(input logic [5:0][5:0][W-1:0] j, input logic [5:0][W-1:0] e,
                                  input logic [W-1:0] a, input logic [5:0] m,
                                  output logic [5:0][W-1:0] d, output logic [5:0] s);
        logic signed [127:0] acc, x, jv, ev, av;
        for (int c = 0; c < 6; c++) begin
            acc = 0;
            for (int r = 0; r < 6; r++) begin
                jv  = $signed(j[r][c]);
                ev  = $signed(e[r]);
                acc = acc + ((jv * ev) >>> 16);
            end
            av = $signed(a);
            x  = (acc * av) >>> 16;
            if (!m[c]) begin
                d[c] = '0; s[c] = 1'b0;
            end else if (x > 128'sd67108863) begin
                d[c] = 27'h3FFFFFF; s[c] = 1'b1;
            end else if (x < -128'sd67108864) begin
                d[c] = 27'h4000000; s[c] = 1'b1;
            end else begin
                d[c] = x[W-1:0]; s[c] = 1'b0;
            end
        end
    endfunction

    // Timing model: phase counts edges since acceptance; result lands at E7, done in the following cycle.
    always @(posedge clk) begin
        if (reset) begin
            phase = -1;
            exp_d = '0;
            exp_s = '0;
        end else if (phase < 0) begin
            if (start) begin
                phase = 0;
                model(jm, pe, alpha, en, pend_d, pend_s);
            end
        end else begin
            phase = phase + 1;
            if (phase == 7) begin
                exp_d = pend_d;
                exp_s = pend_s;
            end
            if (phase == 8) phase = -1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", longint'(busy), longint'(phase >= 0));
            chk("done", longint'(done), longint'(phase == 7));
            for (int c = 0; c < 6; c++)
                chk($sformatf("delta_theta[%0d]", c), longint'($signed(delta_theta[c])), longint'($signed(exp_d[c])));
            chk("sat", longint'(sat), longint'(exp_s));
            if (done) done_cnt++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(9);
    endtask

    task automatic set_identity();
        jm = '0;
        for (int i = 0; i < 6; i++) begin
            jm[i][i] = 27'd65536;
            pe[i]    = 27'd65536;
        end
    endtask

    function automatic logic [W-1:0] rnd_val(input bit wide);
        int v;
        if (wide) return W'($urandom);
        v = int'($urandom_range(0, 262143)) - 131072;
        return W'(v);
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        jm = '0; pe = '0; alpha = '0; en = '0;
        tick(2);
        chk_en = 1'b1;
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        chk("reset delta0", longint'($signed(delta_theta[0])), 0);
        chk("reset sat", longint'(sat), 0);
        reset = 1'b0;
        tick(1);

        // Identity
        set_identity(); alpha = 27'd32768; en = 6'h3F;
        done_cnt = 0;
        run();
        chk("ident done count", done_cnt, 1);
        for (int c = 0; c < 6; c++) chk("ident delta", longint'($signed(delta_theta[c])), 32768);
        chk("ident sat", longint'(sat), 0);

        // Column mixing
        jm = '0;
        for (int r = 0; r < 6; r++) jm[r][2] = W'(65536 * (r + 1));
        alpha = 27'd65536;
        run();
        chk("mix delta2", longint'($signed(delta_theta[2])), 1376256);
        chk("mix delta0", longint'($signed(delta_theta[0])), 0);

        // Saturation both ways
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) jm[r][c] = 27'd131072;
            pe[r] = 27'd6553600;
        end
        run();
        chk("sat pos delta", longint'($signed(delta_theta[3])), 67108863);
        chk("sat pos flags", longint'(sat), 63);
        for (int r = 0; r < 6; r++) pe[r] = W'(-6553600);
        run();
        chk("sat neg delta", longint'($signed(delta_theta[5])), -67108864);
        chk("sat neg flags", longint'(sat), 63);

        // Truncation and mask
        jm = '0; pe = '0; jm[0][0] = 27'd1; pe[0] = '1; en = 6'b000001;
        run();
        chk("trunc delta0", longint'($signed(delta_theta[0])), -1);
        set_identity(); alpha = 27'd32768; en = 6'b111110;
        run();
        chk("mask delta0", longint'($signed(delta_theta[0])), 0);
        chk("mask delta1", longint'($signed(delta_theta[1])), 32768);

        // Busy / snapshot: restart attempt mid-run with changed inputs
        set_identity(); en = 6'h3F;
        start = 1'b1; tick(1); start = 1'b0; tick(2);
        for (int r = 0; r < 6; r++) begin
            pe[r] = rnd_val(1'b0);
            for (int c = 0; c < 6; c++) jm[r][c] = rnd_val(1'b0);
        end
        start = 1'b1; tick(1); start = 1'b0;
        tick(8);
        for (int c = 0; c < 6; c++) chk("snapshot delta", longint'($signed(delta_theta[c])), 32768);
        done_cnt = 0;
        start = 1'b1; tick(18); start = 1'b0; tick(10);
        chk("held start done count", done_cnt, 2);

        // Reset mid-run
        set_identity();
        start = 1'b1; tick(1); start = 1'b0;
        tick(3);
        reset = 1'b1; tick(1); reset = 1'b0;
        chk("midreset busy", longint'(busy), 0);
        chk("midreset delta0", longint'($signed(delta_theta[0])), 0);
        chk("midreset sat", longint'(sat), 0);
        done_cnt = 0;
        tick(10);
        chk("midreset no done", done_cnt, 0);
        run();
        chk("post-reset delta4", longint'($signed(delta_theta[4])), 32768);

        // Randomized runs
        for (int it = 0; it < 60; it++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int r = 0; r < 6; r++) begin
                pe[r] = rnd_val(wide);
                for (int c = 0; c < 6; c++) jm[r][c] = rnd_val(wide);
            end
            alpha = (it % 10 == 9) ? '0 : rnd_val($urandom_range(0, 1) == 1);
            en = 6'($urandom);
            start = 1'b1; tick(1); start = 1'b0;
            tick(9 + int'($urandom_range(0, 3)));
            if (alpha == '0) chk("alpha0 sat", longint'(sat), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ik_jacobian_transpose_step.md
# ik_jacobian_transpose_step

Downstream consumer of the 6×6 Jacobian produced by the full-Jacobian stage in the IK solver. It computes one Jacobian-transpose update, delta_theta = alpha · Jᵀ · e, where e is the 6-element pose error. The six per-joint angle/displacement increments are fed to the joint-angle update stage. Data is 27-bit two's-complement fixed point, matching the Jacobian datapath. The block time-multiplexes 6 multipliers over 6 Jacobian rows.

## Interface

**Parameters**
- W, 27: data word width.
- FRAC, 16: fractional bits of every fixed-point operand and result.

**Ports** (clock and reset first)
- clk  in  1: single clock; all state updates on its rising edge.
- reset  in  1: synchronous, active-high.
- start  in  1: request one update. Sampled only in IDLE.
- jacobian_matrix  in  [5:0][5:0][W-1:0]: J[row][col]. Rows 0–2 are linear and rows 3–5 are angular. The column is the joint.
- pose_error  in  [5:0][W-1:0]: e[row], target minus current pose, in the same row order.
- alpha  in  W: step gain.
- joint_enable  in  6: bit c = 0 forces delta_theta[c] to 0 (locked joint).
- busy  out  1: high from the cycle after start is accepted until done is high.
- done  out  1: one-cycle pulse when delta_theta is valid.
- delta_theta  out  [5:0][W-1:0]: per-joint increment. Holds its value between runs.
- sat  out  6: bit c is set if delta_theta[c] was clipped on the last run.

## Operation

**Reset values.** busy = 0, done = 0, delta_theta = all 0, sat = 0, FSM = IDLE, and all internal accumulators and snapshots are 0.

**States.** IDLE → MAC → SCALE → DONE → IDLE.

- **IDLE**
  - When start = 1: snapshot jacobian_matrix, pose_error, alpha and joint_enable into internal registers, clear acc[5:0], set row counter k = 0, go to MAC.
  - When start = 0: stay in IDLE.
- **MAC** (6 cycles, k = 0..5)
  - For each column c: acc[c] += (J[k][c] · e[k]) >>> FRAC.
  - k increments each cycle. Leave for SCALE after k = 5.
- **SCALE** (1 cycle)
  - s[c] = (acc[c] · alpha) >>> FRAC.
  - Saturate s[c] to the range [−2^(W−1), 2^(W−1)−1] and set sat[c] on clipping.
  - If joint_enable[c] = 0: delta_theta[c] = 0 and sat[c] = 0.
  - delta_theta and sat are registered at the end of this cycle.
- **DONE** (1 cycle)
  - done = 1, then return to IDLE unconditionally.

**Inputs.** Input changes after the start cycle have no effect on the current run, because only the snapshots are used.

**Arithmetic**
- All values are signed two's complement.
- Products are full precision at 2W bits.
- The right shift is arithmetic, so results truncate toward −∞; there is no rounding.
- Accumulator width is ACC_W = 2W − FRAC + 3 (41 bits at the defaults). This holds 6 worst-case terms with no overflow, so only the final result saturates.
- The SCALE product is ACC_W + W bits wide, shifted, then saturated.

**Boundary cases**
- start while busy, or during DONE: ignored. No queueing and no effect on the current run.
- reset at any point mid-run: FSM goes to IDLE next edge. busy, done, delta_theta and sat are cleared, and no done pulse is produced.
- reset and start high in the same cycle: reset wins and the run is not accepted.
- alpha = 0 or e = 0: delta_theta = 0 and sat = 0.

## Timing

- The accepting edge is E0, where start = 1 is sampled in IDLE.
- busy is high in the cycles after E0 through the cycle after E7.
- MAC occupies the cycles after E0..E5. SCALE is the cycle after E6.
- delta_theta and sat update at E7. done = 1 in the cycle after E7, for exactly one cycle; busy is also high in that cycle.
- Latency is 8 cycles from start sampled to done visible.
- Minimum start-to-start spacing is 9 cycles: start held continuously is re-accepted at E9.
- delta_theta stays stable from E7 until E7 of the next run, or until reset.

## Test plan

1. **Identity case.** J = identity (diagonal 65536, others 0), e[r] = 65536 (1.0), alpha = 32768 (0.5), enable = 6'h3F.
   - Required: delta_theta[c] = 32768 for all c, sat = 0.
   - Required: done pulses exactly once, 8 cycles after start.
2. **Column mixing.** J[r][c] = 65536·(r+1) for c = 2 only, others 0; e[r] = 65536; alpha = 65536.
   - Required: delta_theta[2] = 21·65536 = 1376256; all other joints 0.
3. **Saturation.** All J = 131072 (2.0), all e = 6553600 (100.0), alpha = 65536.
   - Required: delta_theta[c] = 67108863 and sat = 6'h3F.
   - Repeat with e = −6553600. Required: delta_theta[c] = −67108864 and sat = 6'h3F.
4. **Truncation and mask.** J[0][0] = 1, e[0] = −1, alpha = 65536, joint_enable = 6'b000001.
   - Required: delta_theta[0] = −1.
   - Rerun with J = identity as in scenario 1 but joint_enable = 6'b111110. Required: delta_theta[0] = 0, others 32768.
5. **Busy and snapshot.** Assert start again 3 cycles after acceptance and change J/e meanwhile.
   - Required: no restart, and the result reflects the original snapshot.
   - Required: start held high re-accepts at 9-cycle spacing.
6. **Reset mid-run.** Assert reset during the MAC phase (cycle after E3).
   - Required: busy = 0 next cycle, no done pulse, delta_theta = 0, sat = 0.
   - Required: a subsequent start completes normally.
